crt_sync_controller: RTL and testbench
======================================

CRT_SYNC_CONTROLLER -- requirements
Module: crt_sync_controller

Interface
REQ-001 Parameter HVisible, default 640, active pixels per line.
REQ-002 Parameter HFront, default 16, horizontal front-porch pixels.
REQ-003 Parameter HSyncW, default 96, horizontal sync-pulse pixels.
REQ-004 Parameter HBack, default 48, horizontal back-porch pixels.
REQ-005 Parameter VVisible, default 480, active lines per frame.
REQ-006 Parameter VFront, default 10, vertical front-porch lines.
REQ-007 Parameter VSyncW, default 2, vertical sync-pulse lines.
REQ-008 Parameter VBack, default 33, vertical back-porch lines.
REQ-009 Parameter SyncActiveLow, default 1, sync polarity: 1 = asserted low.
REQ-010 Clock  input  1  system clock; the only clock; all state changes on its rising edge.
REQ-011 Reset  input  1  synchronous, active-high reset.
REQ-012 PixelClock  input  1  pixel-rate square wave from the CRT clock divider, synchronous to Clock.
REQ-013 HSync  output  1  horizontal sync, polarity per SyncActiveLow.
REQ-014 VSync  output  1  vertical sync, polarity per SyncActiveLow.
REQ-015 HCount  output  10  current pixel column, 0..HTotal-1.
REQ-016 VCount  output  10  current line, 0..VTotal-1.
REQ-017 VideoOn  output  1  high when HCount<HVisible and VCount<VVisible.
REQ-018 FrameStart  output  1  one-Clock pulse when counters step to (0,0).

Function
REQ-019 HTotal = HVisible+HFront+HSyncW+HBack and VTotal = the vertical sum; both SHALL be at most 1024.
REQ-020 Register PixelClock once; Tick = PixelClock AND NOT previous; one pixel step per Tick.
REQ-021 A held-high or held-low PixelClock SHALL produce no further Ticks; the counters freeze.
REQ-022 On a Tick, HCount increments; at HTotal-1 it wraps to 0 on that same edge.
REQ-023 VCount increments only on the Tick where HCount wraps; at VTotal-1 it wraps to 0 on that same edge.
REQ-024 HSync asserted iff HVisible+HFront <= HCount < HVisible+HFront+HSyncW.
REQ-025 VSync asserted iff VVisible+VFront <= VCount < VVisible+VFront+VSyncW.
REQ-026 HSync, VSync and VideoOn are registered and always consistent with the HCount/VCount being output in the same cycle, with zero lag.
REQ-027 FrameStart is high for exactly the one Clock cycle following the edge on which both counters wrap to 0.
REQ-028 Tick is not qualified by Reset; a Tick coincident with Reset is discarded and reset takes priority.

Reset
REQ-029 Reset asserted at any Clock edge SHALL force HCount=0, VCount=0, FrameStart=0, VideoOn=1, HSync and VSync deasserted, and the edge-detect register cleared to 0.
REQ-030 Reset mid-line or mid-frame restarts timing from (0,0); no partial-state carryover.
REQ-031 If PixelClock is high while Reset is released, its first Tick occurs one Clock after release; counting is never immediate.

Structure
REQ-032 Shared package crt_timing_pkg holds the 640x480 default constants and the count width (10).
REQ-033 One sub-module, crt_axis_counter (parameterised visible/front/sync/back, enable in, count/sync/active/wrap out), instantiated twice: horizontal, enabled by Tick; vertical, enabled by Tick AND the horizontal wrap.

Verification
REQ-034 Use small parameters: H 4/1/2/1 (HTotal 8), V 3/1/1/1 (VTotal 6). The bench uses Clock with a period of 8 and a PixelClock divided by 4.
REQ-035 Reset for 20, then 8 Ticks -> HCount 0..7..0. HSync asserted only at HCount 5,6. VCount steps to 1 on the wrap.
REQ-036 Run 48 Ticks -> VSync asserted only on VCount 4. VideoOn high only for HCount<4 and VCount<3. One FrameStart pulse at the 48th Tick.
REQ-037 Hold PixelClock high for 10 Clocks mid-line -> counters and outputs frozen. The first rising edge afterwards advances by exactly 1.
REQ-038 Assert Reset at HCount=6, VCount=4 -> next cycle (0,0), syncs deasserted, FrameStart low. Counting resumes normally.
REQ-039 Tick coincident with Reset -> counters remain (0,0) and are not at (1,0).

Source files
------------

// File: rtl/crt_timing_pkg.sv
// Shared timing constants for the CRT sync controller: 640x480 default
// geometry, counter width and a helper to sum an axis' segments.
package crt_timing_pkg;

    localparam int CountW   = 10;
    localparam int MaxTotal = 1 << CountW;

    localparam int DefHVisible = 640;
    localparam int DefHFront   = 16;
    localparam int DefHSyncW   = 96;
    localparam int DefHBack    = 48;

    localparam int DefVVisible = 480;
    localparam int DefVFront   = 10;
    localparam int DefVSyncW   = 2;
    localparam int DefVBack    = 33;

    function automatic int axisTotal(int visible, int front, int syncW, int back);
        return visible + front + syncW + back;
    endfunction

endpackage

// File: rtl/crt_sync_controller_if.sv
// Video timing bus: pixel-rate strobe in, sync/position/blanking out.
// The controller drives it through the master modport.
interface crt_sync_controller_if;
    import crt_timing_pkg::*;

    logic              pixelClock;
    logic              hSync;
    logic              vSync;
    logic [CountW-1:0] hCount;
    logic [CountW-1:0] vCount;
    logic              videoOn;
    logic              frameStart;

    modport master (
        input  pixelClock,
        output hSync, vSync, hCount, vCount, videoOn, frameStart
    );

    modport slave (
        output pixelClock,
        input  hSync, vSync, hCount, vCount, videoOn, frameStart
    );

endinterface

// File: rtl/crt_axis_counter.sv
// One timing axis: a wrapping position counter whose sync and active flags
// are registered from the next count, so they never lag the count output.
module crt_axis_counter
    import crt_timing_pkg::*;
#(
    parameter int Visible = DefHVisible,
    parameter int Front   = DefHFront,
    parameter int SyncW   = DefHSyncW,
    parameter int Back    = DefHBack
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    output logic [CountW-1:0] o_count,
    output logic              o_sync,
    output logic              o_active,
    output logic              o_wrap
);

    localparam int Total = axisTotal(Visible, Front, SyncW, Back);
    localparam logic [CountW-1:0] LastCount = CountW'(Total - 1);
    localparam logic [CountW-1:0] VisEnd    = CountW'(Visible);
    localparam logic [CountW-1:0] SyncStart = CountW'(Visible + Front);
    localparam logic [CountW-1:0] SyncEnd   = CountW'(Visible + Front + SyncW);

    logic [CountW-1:0] r_count;
    logic              r_sync;
    logic              r_active;
    logic              w_atEnd;
    logic [CountW-1:0] w_nextCount;

    always_comb begin
        w_atEnd     = (r_count == LastCount);
        w_nextCount = r_count;
        if (i_enable) begin
            w_nextCount = w_atEnd ? '0 : r_count + CountW'(1);
        end
    end

    // Flags are derived from the value being loaded, keeping them aligned with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= '0;
            r_sync   <= 1'b0;
            r_active <= 1'b1;
        end else begin
            r_count  <= w_nextCount;
            r_sync   <= (w_nextCount >= SyncStart) && (w_nextCount < SyncEnd);
            r_active <= (w_nextCount < VisEnd);
        end
    end

    assign o_count  = r_count;
    assign o_sync   = r_sync;
    assign o_active = r_active;
    assign o_wrap   = i_enable && w_atEnd;

endmodule

// File: rtl/crt_sync_controller.sv
// CRT sync generator: edge-detects the pixel strobe and drives horizontal and
// vertical axis counters, producing syncs, blanking and a frame-start pulse.
module crt_sync_controller
    import crt_timing_pkg::*;
#(
    parameter int HVisible      = DefHVisible,
    parameter int HFront        = DefHFront,
    parameter int HSyncW        = DefHSyncW,
    parameter int HBack         = DefHBack,
    parameter int VVisible      = DefVVisible,
    parameter int VFront        = DefVFront,
    parameter int VSyncW        = DefVSyncW,
    parameter int VBack         = DefVBack,
    parameter bit SyncActiveLow = 1'b1
) (
    input logic                   i_clk,
    input logic                   i_rst,
    crt_sync_controller_if.master bus
);

    if (axisTotal(HVisible, HFront, HSyncW, HBack) > MaxTotal ||
        axisTotal(VVisible, VFront, VSyncW, VBack) > MaxTotal) begin : g_badGeometry
        $error("crt_sync_controller: axis total exceeds counter range");
    end

    logic r_pixelClockPrev;
    logic r_frameStart;
    logic w_tick;
    logic w_hWrap;
    logic w_vWrap;
    logic w_vEnable;
    logic w_hSync;
    logic w_vSync;
    logic w_hActive;
    logic w_vActive;

    assign w_tick    = bus.pixelClock & ~r_pixelClockPrev;
    assign w_vEnable = w_tick & w_hWrap;

    // Reset overrides any coincident tick because the counters test reset first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pixelClockPrev <= 1'b0;
            r_frameStart     <= 1'b0;
        end else begin
            r_pixelClockPrev <= bus.pixelClock;
            r_frameStart     <= w_vWrap;
        end
    end

    crt_axis_counter #(
        .Visible (HVisible),
        .Front   (HFront),
        .SyncW   (HSyncW),
        .Back    (HBack)
    ) u_hAxis (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (w_tick),
        .o_count  (bus.hCount),
        .o_sync   (w_hSync),
        .o_active (w_hActive),
        .o_wrap   (w_hWrap)
    );

    crt_axis_counter #(
        .Visible (VVisible),
        .Front   (VFront),
        .SyncW   (VSyncW),
        .Back    (VBack)
    ) u_vAxis (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (w_vEnable),
        .o_count  (bus.vCount),
        .o_sync   (w_vSync),
        .o_active (w_vActive),
        .o_wrap   (w_vWrap)
    );

    assign bus.hSync      = SyncActiveLow ? ~w_hSync : w_hSync;
    assign bus.vSync      = SyncActiveLow ? ~w_vSync : w_vSync;
    assign bus.videoOn    = w_hActive & w_vActive;
    assign bus.frameStart = r_frameStart;

endmodule

// File: tb/tb_crt_sync_controller.sv
// Directed bench for crt_sync_controller with an 8x6 geometry (H 4/1/2/1,
// V 3/1/1/1), 8-unit Clock and a PixelClock of four Clock periods.
module tb_crt_sync_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    crt_sync_controller_if bus ();

    crt_sync_controller #(
        .HVisible      (4),
        .HFront        (1),
        .HSyncW        (2),
        .HBack         (1),
        .VVisible      (3),
        .VFront        (1),
        .VSyncW        (1),
        .VBack         (1),
        .SyncActiveLow (1'b1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #4 clk = ~clk;

    // Expected levels for the small geometry: sync is active low.
    function automatic logic expHSync(int h);
        return (h == 5 || h == 6) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic expVSync(int v);
        return (v == 4) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic expVideo(int h, int v);
        return (h < 4 && v < 3) ? 1'b1 : 1'b0;
    endfunction

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        bus.pixelClock = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One pixel period: low one Clock, high two, low one; tick on the first high edge.
    task automatic stepPixel(output int fsPulses);
        fsPulses = 0;
        @(negedge clk);
        bus.pixelClock = 1'b1;
        @(negedge clk);
        if (bus.frameStart === 1'b1) fsPulses++;
        @(negedge clk);
        if (bus.frameStart === 1'b1) fsPulses++;
        bus.pixelClock = 1'b0;
        @(negedge clk);
        if (bus.frameStart === 1'b1) fsPulses++;
    endtask

    task automatic test_reset();
        bus.pixelClock = 1'b0;
        rst = 1'b1;
        #20;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (bus.hCount !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_hcount got %0d want 0", bus.hCount);
        end
        compared++;
        if (bus.vCount !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_vcount got %0d want 0", bus.vCount);
        end
        compared++;
        if (bus.hSync !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_hsync got %b want 1", bus.hSync);
        end
        compared++;
        if (bus.vSync !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_vsync got %b want 1", bus.vSync);
        end
        compared++;
        if (bus.videoOn !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_videoon got %b want 1", bus.videoOn);
        end
        compared++;
        if (bus.frameStart !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_framestart got %b want 0", bus.frameStart);
        end
    endtask

    task automatic test_line();
        int fs;
        for (int k = 1; k <= 8; k++) begin
            int h = k % 8;
            int v = (k == 8) ? 1 : 0;
            stepPixel(fs);
            compared++;
            if (bus.hCount !== 10'(h) || bus.vCount !== 10'(v)) begin
                mismatched++;
                $display("[TB] FAIL line_pos tick %0d got (%0d,%0d) want (%0d,%0d)",
                         k, bus.hCount, bus.vCount, h, v);
            end
            compared++;
            if (bus.hSync !== expHSync(h)) begin
                mismatched++;
                $display("[TB] FAIL line_hsync tick %0d got %b want %b", k, bus.hSync, expHSync(h));
            end
            compared++;
            if (fs !== 0) begin
                mismatched++;
                $display("[TB] FAIL line_framestart tick %0d got %0d pulses want 0", k, fs);
            end
        end
    endtask

    task automatic test_frame();
        int fs;
        doReset();
        for (int k = 1; k <= 48; k++) begin
            int h = k % 8;
            int v = (k / 8) % 6;
            int wantFs = (k == 48) ? 1 : 0;
            stepPixel(fs);
            compared++;
            if (bus.hCount !== 10'(h) || bus.vCount !== 10'(v)) begin
                mismatched++;
                $display("[TB] FAIL frame_pos tick %0d got (%0d,%0d) want (%0d,%0d)",
                         k, bus.hCount, bus.vCount, h, v);
            end
            compared++;
            if (bus.hSync !== expHSync(h) || bus.vSync !== expVSync(v)) begin
                mismatched++;
                $display("[TB] FAIL frame_sync tick %0d got h%b v%b want h%b v%b",
                         k, bus.hSync, bus.vSync, expHSync(h), expVSync(v));
            end
            compared++;
            if (bus.videoOn !== expVideo(h, v)) begin
                mismatched++;
                $display("[TB] FAIL frame_videoon tick %0d got %b want %b", k, bus.videoOn, expVideo(h, v));
            end
            compared++;
            if (fs !== wantFs) begin
                mismatched++;
                $display("[TB] FAIL frame_framestart tick %0d got %0d pulses want %0d", k, fs, wantFs);
            end
        end
    endtask

    task automatic test_hold();
        int fs;
        doReset();
        repeat (3) stepPixel(fs);
        @(negedge clk);
        bus.pixelClock = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.hCount !== 10'd4) begin
            mismatched++;
            $display("[TB] FAIL hold_entry got %0d want 4", bus.hCount);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            compared++;
            if (bus.hCount !== 10'd4 || bus.vCount !== 10'd0 ||
                bus.hSync !== 1'b1 || bus.videoOn !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL hold_frozen clk %0d got (%0d,%0d) hs%b vo%b want (4,0) hs1 vo0",
                         c, bus.hCount, bus.vCount, bus.hSync, bus.videoOn);
            end
        end
        bus.pixelClock = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.hCount !== 10'd4) begin
            mismatched++;
            $display("[TB] FAIL hold_fall got %0d want 4", bus.hCount);
        end
        bus.pixelClock = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.hCount !== 10'd5 || bus.hSync !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hold_resume got %0d hs%b want 5 hs0", bus.hCount, bus.hSync);
        end
        @(negedge clk);
        compared++;
        if (bus.hCount !== 10'd5) begin
            mismatched++;
            $display("[TB] FAIL hold_single_step got %0d want 5", bus.hCount);
        end
        bus.pixelClock = 1'b0;
    endtask

    task automatic test_reset_mid();
        int fs;
        doReset();
        repeat (38) stepPixel(fs);
        compared++;
        if (bus.hCount !== 10'd6 || bus.vCount !== 10'd4 ||
            bus.hSync !== 1'b0 || bus.vSync !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_setup got (%0d,%0d) hs%b vs%b want (6,4) hs0 vs0",
                     bus.hCount, bus.vCount, bus.hSync, bus.vSync);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (bus.hCount !== 10'd0 || bus.vCount !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_pos got (%0d,%0d) want (0,0)", bus.hCount, bus.vCount);
        end
        compared++;
        if (bus.hSync !== 1'b1 || bus.vSync !== 1'b1 ||
            bus.frameStart !== 1'b0 || bus.videoOn !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_flags got hs%b vs%b fs%b vo%b want hs1 vs1 fs0 vo1",
                     bus.hSync, bus.vSync, bus.frameStart, bus.videoOn);
        end
        stepPixel(fs);
        compared++;
        if (bus.hCount !== 10'd1 || bus.vCount !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL mid_resume got (%0d,%0d) want (1,0)", bus.hCount, bus.vCount);
        end
    endtask

    task automatic test_tick_reset();
        int fs;
        doReset();
        repeat (2) stepPixel(fs);
        compared++;
        if (bus.hCount !== 10'd2) begin
            mismatched++;
            $display("[TB] FAIL tickrst_setup got %0d want 2", bus.hCount);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.pixelClock = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (bus.hCount !== 10'd0 || bus.vCount !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL tickrst_discard got (%0d,%0d) want (0,0)", bus.hCount, bus.vCount);
        end
        @(negedge clk);
        compared++;
        if (bus.hCount !== 10'd1 || bus.vCount !== 10'd0) begin
            mismatched++;
            $display("[TB] FAIL tickrst_release got (%0d,%0d) want (1,0)", bus.hCount, bus.vCount);
        end
        @(negedge clk);
        compared++;
        if (bus.hCount !== 10'd1) begin
            mismatched++;
            $display("[TB] FAIL tickrst_single got %0d want 1", bus.hCount);
        end
        bus.pixelClock = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.pixelClock = 1'b0;
        test_reset();
        test_line();
        test_frame();
        test_hold();
        test_reset_mid();
        test_tick_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
